i2s_clk_gen: RTL and testbench

I2S_CLK_GEN -- requirements
Module: i2s_clk_gen

---
 rtl/i2s_clk_gen_if.sv | 30 +++
 rtl/i2s_clk_gen.sv | 128 ++++++++++++
 tb/tb_i2s_clk_gen.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/i2s_clk_gen_if.sv
// Bus between the I2S clock generator and its consumers: run enable in,
// serial clocks, strobes and the current frame position out.
interface i2s_clk_gen_if #(
   parameter int DW    = 24,
   parameter int SLOTS = 2
);
   localparam int SW = $clog2(SLOTS);
   localparam int BW = $clog2(DW);

   logic          en;
   logic          sclk;
   logic          lrclk;
   logic          fall_stb;
   logic          rise_stb;
   logic          frame_stb;
   logic [SW-1:0] slot_idx;
   logic [BW-1:0] bit_idx;

   // Generator side: consumes the enable, drives every timing signal.
   modport master (
      input  en,
      output sclk, lrclk, fall_stb, rise_stb, frame_stb, slot_idx, bit_idx
   );

   // Consumer side: drives the enable, observes the timing signals.
   modport slave (
      output en,
      input  sclk, lrclk, fall_stb, rise_stb, frame_stb, slot_idx, bit_idx
   );
endinterface

// File: rtl/i2s_clk_gen.sv
// I2S / left-justified / DSP-TDM bit and frame clock generator.
// A divider toggles sclk every SCLK_DIV clk cycles; the frame position
// (slot_idx, bit_idx) advances on every sclk fall and lrclk is recomputed
// from the position just entered. All outputs come straight from flops.
module i2s_clk_gen #(
   parameter int DW       = 24,
   parameter int SLOTS    = 2,
   parameter int SCLK_DIV = 4,
   parameter int MODE     = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   i2s_clk_gen_if.master bus
);
   localparam int SW    = $clog2(SLOTS);
   localparam int BW    = $clog2(DW);
   localparam int FRAME = SLOTS * DW;
   localparam int PW    = $clog2(FRAME + 1);
   localparam int DIVW  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

   localparam logic [DIVW-1:0] DIV_LAST   = DIVW'(SCLK_DIV - 1);
   localparam logic [BW-1:0]   BIT_LAST   = BW'(DW - 1);
   localparam logic [SW-1:0]   SLOT_LAST  = SW'(SLOTS - 1);
   localparam logic [PW-1:0]   FRAME_LAST = PW'(FRAME - 1);
   localparam logic [PW-1:0]   HALF       = PW'(FRAME / 2);
   localparam logic [PW-1:0]   DW_P       = PW'(DW);
   localparam logic [1:0]      MODE_SEL   = 2'(MODE);
   // lrclk idles high for the stereo formats and low for pulse sync
   localparam logic            LR_RST     = (MODE == 2) ? 1'b0 : 1'b1;

   logic [DIVW-1:0] div_r;
   logic            sclk_r;
   logic            lrclk_r;
   logic            fall_stb_r;
   logic            rise_stb_r;
   logic            frame_stb_r;
   logic [SW-1:0]   slot_r;
   logic [BW-1:0]   bit_r;

   logic [BW-1:0]   nxt_bit_s;
   logic [SW-1:0]   nxt_slot_s;
   logic            wrap_s;
   logic [PW-1:0]   nxt_p_s;
   logic [PW-1:0]   p_inc_s;
   logic            lr_nxt_s;

   // Position the next sclk fall will enter, and the lrclk level there.
   always_comb begin
      nxt_bit_s  = bit_r;
      nxt_slot_s = slot_r;
      wrap_s     = 1'b0;
      p_inc_s    = {PW{1'b0}};
      lr_nxt_s   = lrclk_r;
      if (bit_r == BIT_LAST) begin
         nxt_bit_s = {BW{1'b0}};
         if (slot_r == SLOT_LAST) begin
            nxt_slot_s = {SW{1'b0}};
            wrap_s     = 1'b1;
         end else begin
            nxt_slot_s = slot_r + SW'(1);
         end
      end else begin
         nxt_bit_s = bit_r + BW'(1);
      end
      nxt_p_s = PW'(nxt_slot_s) * DW_P + PW'(nxt_bit_s);
      // I2S looks one bit ahead so word-select leads the MSB by one sclk
      if (nxt_p_s == FRAME_LAST) begin
         p_inc_s = {PW{1'b0}};
      end else begin
         p_inc_s = nxt_p_s + PW'(1);
      end
      case (MODE_SEL)
         2'd0:    lr_nxt_s = (p_inc_s >= HALF);
         2'd1:    lr_nxt_s = (nxt_p_s >= HALF);
         default: lr_nxt_s = (nxt_p_s == {PW{1'b0}});
      endcase
   end

   // Divider, sclk, strobes and frame position; idle parks at the last position.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_r       <= {DIVW{1'b0}};
         sclk_r      <= 1'b0;
         lrclk_r     <= LR_RST;
         fall_stb_r  <= 1'b0;
         rise_stb_r  <= 1'b0;
         frame_stb_r <= 1'b0;
         slot_r      <= SLOT_LAST;
         bit_r       <= BIT_LAST;
      end else if (!bus.en) begin
         div_r       <= {DIVW{1'b0}};
         sclk_r      <= 1'b0;
         lrclk_r     <= LR_RST;
         fall_stb_r  <= 1'b0;
         rise_stb_r  <= 1'b0;
         frame_stb_r <= 1'b0;
         slot_r      <= SLOT_LAST;
         bit_r       <= BIT_LAST;
      end else begin
         fall_stb_r  <= 1'b0;
         rise_stb_r  <= 1'b0;
         frame_stb_r <= 1'b0;
         if (div_r == DIV_LAST) begin
            div_r  <= {DIVW{1'b0}};
            sclk_r <= ~sclk_r;
            if (sclk_r) begin
               fall_stb_r  <= 1'b1;
               frame_stb_r <= wrap_s;
               slot_r      <= nxt_slot_s;
               bit_r       <= nxt_bit_s;
               lrclk_r     <= lr_nxt_s;
            end else begin
               rise_stb_r  <= 1'b1;
            end
         end else begin
            div_r <= div_r + DIVW'(1);
         end
      end
   end

   assign bus.sclk      = sclk_r;
   assign bus.lrclk     = lrclk_r;
   assign bus.fall_stb  = fall_stb_r;
   assign bus.rise_stb  = rise_stb_r;
   assign bus.frame_stb = frame_stb_r;
   assign bus.slot_idx  = slot_r;
   assign bus.bit_idx   = bit_r;
endmodule

// File: tb/tb_i2s_clk_gen.sv
// Directed bench for i2s_clk_gen: three instances share clk/rst_n/en --
// 16x2 left-justified (a), 16x2 I2S (b), 32x8 DSP pulse with SCLK_DIV=1 (c).
// Expected values are hand-computed per cycle after en rises.
module tb_i2s_clk_gen;
   typedef struct {
      int n;
      int sclk;
      int rise;
      int fall;
      int frame;
      int slot;
      int bitv;
      int lr;
      int lr_alt;
   } vec_t;

   logic clk;
   logic rst_n;
   logic en;
   int   cyc;
   int   n_pass;
   int   n_total;
   vec_t tab_ab[$];
   vec_t tab_c[$];

   i2s_clk_gen_if #(.DW(16), .SLOTS(2)) bus_a ();
   i2s_clk_gen_if #(.DW(16), .SLOTS(2)) bus_b ();
   i2s_clk_gen_if #(.DW(32), .SLOTS(8)) bus_c ();

   assign bus_a.en = en;
   assign bus_b.en = en;
   assign bus_c.en = en;

   i2s_clk_gen #(.DW(16), .SLOTS(2), .SCLK_DIV(4), .MODE(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a.master));
   i2s_clk_gen #(.DW(16), .SLOTS(2), .SCLK_DIV(4), .MODE(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b.master));
   i2s_clk_gen #(.DW(32), .SLOTS(8), .SCLK_DIV(1), .MODE(2)) dut_c (
      .clk(clk), .rst_n(rst_n), .bus(bus_c.master));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic vec_t mk(int n, int sclk, int rise, int fall, int frame,
                               int slot, int bitv, int lr, int lr_alt);
      vec_t v;
      v.n = n; v.sclk = sclk; v.rise = rise; v.fall = fall; v.frame = frame;
      v.slot = slot; v.bitv = bitv; v.lr = lr; v.lr_alt = lr_alt;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ab(input vec_t v);
      chk($sformatf("a_sclk@%0d", v.n),  int'(bus_a.sclk),      v.sclk);
      chk($sformatf("a_rise@%0d", v.n),  int'(bus_a.rise_stb),  v.rise);
      chk($sformatf("a_fall@%0d", v.n),  int'(bus_a.fall_stb),  v.fall);
      chk($sformatf("a_frame@%0d", v.n), int'(bus_a.frame_stb), v.frame);
      chk($sformatf("a_slot@%0d", v.n),  int'(bus_a.slot_idx),  v.slot);
      chk($sformatf("a_bit@%0d", v.n),   int'(bus_a.bit_idx),   v.bitv);
      chk($sformatf("a_lrclk@%0d", v.n), int'(bus_a.lrclk),     v.lr);
      chk($sformatf("b_lrclk@%0d", v.n), int'(bus_b.lrclk),     v.lr_alt);
   endtask

   task automatic chk_c(input vec_t v);
      chk($sformatf("c_sclk@%0d", v.n),  int'(bus_c.sclk),      v.sclk);
      chk($sformatf("c_rise@%0d", v.n),  int'(bus_c.rise_stb),  v.rise);
      chk($sformatf("c_fall@%0d", v.n),  int'(bus_c.fall_stb),  v.fall);
      chk($sformatf("c_frame@%0d", v.n), int'(bus_c.frame_stb), v.frame);
      chk($sformatf("c_slot@%0d", v.n),  int'(bus_c.slot_idx),  v.slot);
      chk($sformatf("c_bit@%0d", v.n),   int'(bus_c.bit_idx),   v.bitv);
      chk($sformatf("c_lrclk@%0d", v.n), int'(bus_c.lrclk),     v.lr);
   endtask

   // Idle / reset values of all three instances.
   task automatic chk_idle(input string tag);
      chk_ab(mk(-1, 0, 0, 0, 0, 1, 15, 1, 1));
      chk_c(mk(-1, 0, 0, 0, 0, 7, 31, 0, 0));
      chk({tag, "_b_sclk"}, int'(bus_b.sclk), 0);
   endtask

   initial begin
      int fr_a;
      int fr_c;
      int overlap_a;
      int alt_err_c;
      cyc = 0; n_pass = 0; n_total = 0;
      en = 1'b0;
      rst_n = 1'b1;

      // a/b: sclk period 8, fall entering p at n = 8*(p+1)
      tab_ab.push_back(mk(0,   0,0,0,0, 1,15, 1,1));
      tab_ab.push_back(mk(3,   0,0,0,0, 1,15, 1,1));
      tab_ab.push_back(mk(4,   1,1,0,0, 1,15, 1,1));
      tab_ab.push_back(mk(7,   1,0,0,0, 1,15, 1,1));
      tab_ab.push_back(mk(8,   0,0,1,1, 0,0,  0,0));
      tab_ab.push_back(mk(9,   0,0,0,0, 0,0,  0,0));
      tab_ab.push_back(mk(12,  1,1,0,0, 0,0,  0,0));
      tab_ab.push_back(mk(16,  0,0,1,0, 0,1,  0,0));
      tab_ab.push_back(mk(120, 0,0,1,0, 0,14, 0,0));
      tab_ab.push_back(mk(128, 0,0,1,0, 0,15, 0,1));
      tab_ab.push_back(mk(136, 0,0,1,0, 1,0,  1,1));
      tab_ab.push_back(mk(248, 0,0,1,0, 1,14, 1,1));
      tab_ab.push_back(mk(256, 0,0,1,0, 1,15, 1,0));
      tab_ab.push_back(mk(260, 1,1,0,0, 1,15, 1,0));
      tab_ab.push_back(mk(263, 1,0,0,0, 1,15, 1,0));
      tab_ab.push_back(mk(264, 0,0,1,1, 0,0,  0,0));
      tab_ab.push_back(mk(520, 0,0,1,1, 0,0,  0,0));

      // c: sclk period 2, fall entering p at n = 2*(p+1)
      tab_c.push_back(mk(0,   0,0,0,0, 7,31, 0,0));
      tab_c.push_back(mk(1,   1,1,0,0, 7,31, 0,0));
      tab_c.push_back(mk(2,   0,0,1,1, 0,0,  1,0));
      tab_c.push_back(mk(3,   1,1,0,0, 0,0,  1,0));
      tab_c.push_back(mk(4,   0,0,1,0, 0,1,  0,0));
      for (int s = 1; s < 8; s++) tab_c.push_back(mk(64*s + 2, 0,0,1,0, s,0, 0,0));
      tab_c.push_back(mk(512, 0,0,1,0, 7,31, 0,0));
      tab_c.push_back(mk(514, 0,0,1,1, 0,0,  1,0));
      tab_c.push_back(mk(515, 1,1,0,0, 0,0,  1,0));
      tab_c.push_back(mk(516, 0,0,1,0, 0,1,  0,0));

      // Asynchronous reset with no clk edge in between
      #1 rst_n = 1'b0;
      #1 chk_idle("reset");
      while (cyc < 3) tick();
      rst_n = 1'b1;
      while (cyc < 10) tick();

      // en rises right after cycle 10
      en = 1'b1;
      fr_a = 0; fr_c = 0; overlap_a = 0; alt_err_c = 0;
      for (int n = 0; n <= 530; n++) begin
         if (n > 0) tick();
         foreach (tab_ab[i]) if (tab_ab[i].n == n) chk_ab(tab_ab[i]);
         foreach (tab_c[i])  if (tab_c[i].n == n)  chk_c(tab_c[i]);
         if (n == 4) chk("first_rise_cycle", cyc, 14);
         if (n == 8) chk("first_frame_cycle", cyc, 18);
         if (bus_a.frame_stb) fr_a++;
         if (bus_c.frame_stb) fr_c++;
         if (bus_a.rise_stb && bus_a.fall_stb) overlap_a++;
         if (n >= 1 && (bus_c.rise_stb == bus_c.fall_stb)) alt_err_c++;
      end
      chk("a_frame_count", fr_a, 3);
      chk("c_frame_count", fr_c, 2);
      chk("a_rise_fall_overlap", overlap_a, 0);
      chk("c_rise_fall_alternate_err", alt_err_c, 0);

      // en low: idle on the very next edge
      en = 1'b0;
      tick();
      chk_idle("stop1");

      // Run to p=7, drop en mid-frame, then restart
      en = 1'b1;
      for (int n = 1; n <= 66; n++) tick();
      chk("p7_slot", int'(bus_a.slot_idx), 0);
      chk("p7_bit", int'(bus_a.bit_idx), 7);
      en = 1'b0;
      tick();
      chk_idle("stop_p7");
      en = 1'b1;
      for (int n = 1; n <= 8; n++) begin
         tick();
         if (n == 2) chk("restart_c_frame", int'(bus_c.frame_stb), 1);
         if (n == 7) chk("restart_a_frame_early", int'(bus_a.frame_stb), 0);
         if (n == 8) begin
            chk("restart_a_frame", int'(bus_a.frame_stb), 1);
            chk("restart_a_slot", int'(bus_a.slot_idx), 0);
            chk("restart_a_bit", int'(bus_a.bit_idx), 0);
         end
      end

      // Mid-frame async reset between clk edges
      for (int n = 9; n <= 100; n++) tick();
      chk("pre_rst_a_rise", int'(bus_a.rise_stb), 1);
      chk("pre_rst_a_bit", int'(bus_a.bit_idx), 11);
      #2 rst_n = 1'b0;
      #1 chk_idle("midrst");
      en = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      chk_idle("post_rst");
      en = 1'b1;
      for (int n = 1; n <= 8; n++) begin
         tick();
         if (n == 3) chk("rst_restart_rise_early", int'(bus_a.rise_stb), 0);
         if (n == 4) chk("rst_restart_rise", int'(bus_a.rise_stb), 1);
         if (n == 8) begin
            chk("rst_restart_frame", int'(bus_a.frame_stb), 1);
            chk("rst_restart_slot", int'(bus_a.slot_idx), 0);
            chk("rst_restart_bit", int'(bus_a.bit_idx), 0);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
